// File: rtl/io_mmio_bridge_if.sv
// Core memory-port and UART-side signal bundle for the I/O endpoint.
// slave = the bridge, master = the core/UART side driving it.
interface io_mmio_bridge_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  io_din;
    logic        io_sel;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        output io_din, io_sel, io_buffer_full, tx_data, tx_valid, rx_ready, program_done
    );

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        input  io_din, io_sel, io_buffer_full, tx_data, tx_valid, rx_ready, program_done
    );
endinterface

// File: rtl/io_mmio_bridge.sv
// MMIO endpoint for the 0x3xxxx window: UART TX FIFO, RX holding register,
// cycle counter with snapshot read-back, and the program-stop sequencer.
module io_mmio_bridge #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    io_mmio_bridge_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cyc_cnt, snap;
    logic          rx_full;
    logic [7:0]    rx_byte;
    logic [7:0]    io_din;
    logic          io_sel;
    logic          program_done;
    logic [1:0]    state, state_next;

    logic          io_acc, io_wr, io_rd, rx_pop, rx_take;
    logic          tx_valid, tx_pop, core_push, term_push, push;
    logic [7:0]    push_data, rd_data;
    logic          unused_addr;

    assign unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

    assign io_acc = bus.rdy_in && (bus.mem_a[17:16] == 2'b11);
    assign io_wr  = io_acc && bus.mem_wr;
    assign io_rd  = io_acc && !bus.mem_wr;
    assign rx_pop = io_rd && !bus.mem_a[2] && (bus.mem_a[1:0] == 2'b00);

    assign rx_take = bus.rx_valid && (!rx_full || rx_pop);

    // Terminator push only happens in DRAIN, core pushes only in RUN: never both.
    assign tx_valid  = (count != '0);
    assign tx_pop    = tx_valid && bus.tx_ready;
    assign core_push = io_wr && !bus.mem_a[2] && (bus.mem_dout != 8'h00) && (state == RUN);
    assign term_push = (state == DRAIN) && (count < CW'(DEPTH));
    assign push      = (core_push || term_push) && ((count != CW'(DEPTH)) || tx_pop);
    assign push_data = term_push ? 8'h00 : bus.mem_dout;

    always_comb begin
        rd_data = 8'h00;
        if (!bus.mem_a[2]) begin
            if ((bus.mem_a[1:0] == 2'b00) && rx_full) rd_data = rx_byte;
        end else begin
            case (bus.mem_a[1:0])
                2'd0: rd_data = cyc_cnt[7:0];
                2'd1: rd_data = snap[15:8];
                2'd2: rd_data = snap[23:16];
                2'd3: rd_data = snap[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= RUN;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:   if (io_wr && bus.mem_a[2])   state_next = DRAIN;
            DRAIN: if (count < CW'(DEPTH))      state_next = FLUSH;
            FLUSH: if (count == '0)             state_next = DONE;
            DONE:                               state_next = DONE;
            default:                            state_next = RUN;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cyc_cnt      <= '0;
            snap         <= '0;
            rx_full      <= 1'b0;
            rx_byte      <= 8'h00;
            io_din       <= 8'h00;
            io_sel       <= 1'b0;
            program_done <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (tx_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, tx_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bus.rdy_in) cyc_cnt <= cyc_cnt + 32'd1;
            if (io_rd && bus.mem_a[2] && (bus.mem_a[1:0] == 2'b00)) snap <= cyc_cnt;

            io_sel <= io_rd;
            if (io_rd) io_din <= rd_data;

            if (rx_take)     rx_full <= 1'b1;
            else if (rx_pop) rx_full <= 1'b0;
            if (rx_take)     rx_byte <= bus.rx_data;

            if (state_next == DONE) program_done <= 1'b1;
        end
    end

    assign bus.io_din         = io_din;
    assign bus.io_sel         = io_sel;
    assign bus.io_buffer_full = (count >= CW'(DEPTH - FULL_MARGIN));
    assign bus.tx_data        = fifo_mem[rd_ptr];
    assign bus.tx_valid       = tx_valid;
    assign bus.rx_ready       = !rx_full || rx_pop;
    assign bus.program_done   = program_done;
endmodule

// File: tb/tb_io_mmio_bridge.sv
// Directed-vector bench for io_mmio_bridge: TX FIFO, full/drop, counter
// snapshot, RX holding register and the stop/drain sequence.
module tb_io_mmio_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_mmio_bridge_if bus_if ();

    io_mmio_bridge #(.DEPTH(16), .FULL_MARGIN(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_if)
    );

    int nvec = 0;
    int nerr = 0;
    logic [31:0] m_cnt;

    // Reference cycle counter: counts every rdy_in cycle out of reset.
    always @(posedge clk) begin
        if (!rst_n)             m_cnt <= 32'd0;
        else if (bus_if.rdy_in) m_cnt <= m_cnt + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus_if.rdy_in   = rdy;
        bus_if.mem_a    = a;
        bus_if.mem_wr   = wr;
        bus_if.mem_dout = d;
    endtask

    task automatic idle();
        drive(1'b1, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic acc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        drive(1'b1, a, wr, d);
        tick(1);
        idle();
    endtask

    logic [7:0] stop_seq [4];
    logic [7:0] snap_lo;

    initial begin
        drive(1'b0, 32'h0, 1'b0, 8'h00);
        bus_if.tx_ready = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        stop_seq[0] = 8'h78; stop_seq[1] = 8'h79; stop_seq[2] = 8'h7A; stop_seq[3] = 8'h00;

        // Reset, then exactly 10 idle rdy cycles
        tick(3);
        rst_n = 1'b1;
        idle();
        check("rst_io_din",  32'(bus_if.io_din), 32'h0);
        check("rst_pdone",   32'(bus_if.program_done), 32'h0);
        tick(10);
        check("idle_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        check("idle_buf_full", 32'(bus_if.io_buffer_full), 32'h0);
        check("idle_rx_ready", 32'(bus_if.rx_ready), 32'h1);
        check("idle_io_sel",   32'(bus_if.io_sel), 32'h0);
        acc(32'h30004, 1'b0, 8'h00);
        check("cnt_read_byte0", 32'(bus_if.io_din), 32'h0A);
        check("cnt_read_sel",   32'(bus_if.io_sel), 32'h1);
        tick(1);
        check("idle_sel_clear", 32'(bus_if.io_sel), 32'h0);
        check("idle_din_hold",  32'(bus_if.io_din), 32'h0A);

        // Streaming writes with UART always ready; zero is filtered
        bus_if.tx_ready = 1'b1;
        acc(32'h30000, 1'b1, 8'h41);
        check("tx_a_valid", 32'(bus_if.tx_valid), 32'h1);
        check("tx_a_data",  32'(bus_if.tx_data), 32'h41);
        acc(32'h30000, 1'b1, 8'h42);
        check("tx_b_data",  32'(bus_if.tx_data), 32'h42);
        acc(32'h30000, 1'b1, 8'h00);
        check("tx_zero_drop", 32'(bus_if.tx_valid), 32'h0);
        acc(32'h30000, 1'b1, 8'h43);
        check("tx_c_data",  32'(bus_if.tx_data), 32'h43);
        tick(1);
        check("tx_empty",   32'(bus_if.tx_valid), 32'h0);

        // Fill to full threshold and overflow
        bus_if.tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            acc(32'h30000, 1'b1, 8'(i));
            if (i == 13) check("full_at13", 32'(bus_if.io_buffer_full), 32'h0);
        end
        check("full_at14", 32'(bus_if.io_buffer_full), 32'h1);
        for (int i = 15; i <= 17; i++) acc(32'h30000, 1'b1, 8'(i));
        check("full_at16", 32'(bus_if.io_buffer_full), 32'h1);
        bus_if.tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", 32'(bus_if.tx_valid), 32'h1);
            check("drain_data",  32'(bus_if.tx_data), 32'(i));
            tick(1);
        end
        check("drain_done",      32'(bus_if.tx_valid), 32'h0);
        check("drain_full_low",  32'(bus_if.io_buffer_full), 32'h0);

        // Counter snapshot across a byte-1 carry
        for (int k = 0; k < 2000 && m_cnt != 32'h2FE; k++) tick(1);
        acc(32'h30001, 1'b0, 8'h00);
        check("rd_30001_sel", 32'(bus_if.io_sel), 32'h1);
        check("rd_30001_din", 32'(bus_if.io_din), 32'h0);
        drive(1'b0, 32'h30004, 1'b0, 8'h00);
        tick(5);
        check("frozen_sel", 32'(bus_if.io_sel), 32'h0);
        check("frozen_din", 32'(bus_if.io_din), 32'h0);
        snap_lo = m_cnt[7:0];
        acc(32'h30004, 1'b0, 8'h00);
        check("snap_b0", 32'(bus_if.io_din), 32'(snap_lo));
        check("snap_b0_sel", 32'(bus_if.io_sel), 32'h1);
        acc(32'h30005, 1'b0, 8'h00);
        check("snap_b1", 32'(bus_if.io_din), 32'h02);
        check("snap_b1_sel", 32'(bus_if.io_sel), 32'h1);
        acc(32'h30006, 1'b0, 8'h00);
        check("snap_b2", 32'(bus_if.io_din), 32'h00);
        acc(32'h30007, 1'b0, 8'h00);
        check("snap_b3", 32'(bus_if.io_din), 32'h00);
        check("snap_b3_sel", 32'(bus_if.io_sel), 32'h1);

        // RX holding register
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        #1;
        check("rx_ready_empty", 32'(bus_if.rx_ready), 32'h1);
        tick(1);
        bus_if.rx_data = 8'h66;
        #1;
        check("rx_ready_full", 32'(bus_if.rx_ready), 32'h0);
        tick(2);
        check("rx_hold_ready", 32'(bus_if.rx_ready), 32'h0);
        drive(1'b1, 32'h30000, 1'b0, 8'h00);
        #1;
        check("rx_ready_on_pop", 32'(bus_if.rx_ready), 32'h1);
        tick(1);
        idle();
        bus_if.rx_valid = 1'b0;
        check("rx_read_55", 32'(bus_if.io_din), 32'h55);
        acc(32'h30000, 1'b0, 8'h00);
        check("rx_read_66", 32'(bus_if.io_din), 32'h66);
        acc(32'h30000, 1'b0, 8'h00);
        check("rx_read_00", 32'(bus_if.io_din), 32'h00);
        check("rx_ready_end", 32'(bus_if.rx_ready), 32'h1);

        // Stop sequence: queued bytes, then terminator, then done
        bus_if.tx_ready = 1'b0;
        acc(32'h30000, 1'b1, 8'h78);
        acc(32'h30000, 1'b1, 8'h79);
        acc(32'h30000, 1'b1, 8'h7A);
        acc(32'h30004, 1'b1, 8'h99);
        acc(32'h30000, 1'b1, 8'h5A);
        check("stop_pd_early", 32'(bus_if.program_done), 32'h0);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stop_valid", 32'(bus_if.tx_valid), 32'h1);
            check("stop_data",  32'(bus_if.tx_data), 32'(stop_seq[i]));
            tick(1);
        end
        check("stop_empty", 32'(bus_if.tx_valid), 32'h0);
        check("stop_pd_empty_cycle", 32'(bus_if.program_done), 32'h0);
        tick(1);
        check("stop_pd_set", 32'(bus_if.program_done), 32'h1);
        acc(32'h30000, 1'b1, 8'h41);
        check("done_write_ignored", 32'(bus_if.tx_valid), 32'h0);
        tick(3);
        check("stop_pd_sticky", 32'(bus_if.program_done), 32'h1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("pd_cleared", 32'(bus_if.program_done), 32'h0);
        check("post_rst_tx_valid", 32'(bus_if.tx_valid), 32'h0);

        // Reset with bytes queued discards them
        bus_if.tx_ready = 1'b0;
        acc(32'h30000, 1'b1, 8'h11);
        acc(32'h30000, 1'b1, 8'h22);
        check("queued_valid", 32'(bus_if.tx_valid), 32'h1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rst_discard_valid", 32'(bus_if.tx_valid), 32'h0);
        check("rst_discard_full",  32'(bus_if.io_buffer_full), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
